// File: rtl/serdiv_wb_pad_sc.sv
// Writeback buffer for serdiv_sc results: public results pass after one cycle,
// secret results are released at a fixed cycle count after issue.
module serdiv_wb_pad_sc #(
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned PAD_CYCLES    = 70,
    parameter int unsigned TRANS_ID_BITS = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     issue_i,
    input  logic                     issue_label_i,
    input  logic                     in_vld_i,
    output logic                     in_rdy_o,
    input  logic [TRANS_ID_BITS-1:0] id_i,
    input  logic [WIDTH-1:0]         res_i,
    input  logic                     res_label_i,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic [TRANS_ID_BITS-1:0] id_o,
    output logic [WIDTH-1:0]         res_o,
    output logic                     res_label_o,
    output logic                     err_o
);

    localparam int unsigned CNT_W = $clog2(PAD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PAD_CYCLES);
    // cnt reads k-1 in cycle k after issue; reaching this value means out_vld_o is due next cycle
    localparam logic [CNT_W-1:0] CNT_REL = CNT_W'(PAD_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        VALID = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             sec_q, sec_d;
    logic             capture;
    logic             err_d;

    assign in_rdy_o = (state_q == WAIT);

    // Next-state, counter and error logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sec_d   = sec_q;
        capture = 1'b0;
        err_d   = err_o;
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        if (issue_i && (state_q != IDLE)) begin
            err_d = 1'b1;
        end

        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue_i) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        sec_d   = issue_label_i;
                    end
                end
                WAIT: begin
                    cnt_d = cnt_inc;
                    if (in_vld_i) begin
                        capture = 1'b1;
                        sec_d   = sec_q | res_label_i;
                        if (!sec_d) begin
                            state_d = VALID;
                        end else if (cnt_q >= CNT_REL) begin
                            state_d = VALID;
                            err_d   = 1'b1;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    cnt_d = cnt_inc;
                    if (cnt_q >= CNT_REL) begin
                        state_d = VALID;
                    end
                end
                VALID: begin
                    if (out_rdy_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sec_q       <= 1'b0;
            err_o       <= 1'b0;
            out_vld_o   <= 1'b0;
            id_o        <= '0;
            res_o       <= '0;
            res_label_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sec_q     <= sec_d;
            err_o     <= err_d;
            out_vld_o <= (state_d == VALID);
            if (capture) begin
                id_o        <= id_i;
                res_o       <= res_i;
                res_label_o <= sec_d;
            end
        end
    end

endmodule

// File: tb/tb_serdiv_wb_pad_sc.sv
// Directed bench for serdiv_wb_pad_sc: public/secret timing, backpressure,
// flush, pad overrun and protocol error.
module tb_serdiv_wb_pad_sc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue = 1'b0;
    logic        issue_label = 1'b0;
    logic        in_vld = 1'b0;
    logic [3:0]  id_in = '0;
    logic [63:0] res_in = '0;
    logic        res_label = 1'b0;
    logic        out_rdy = 1'b0;

    logic        in_rdy, out_vld, lab, err;
    logic [3:0]  id_out;
    logic [63:0] res_out;
    logic        in_rdy8, out_vld8, lab8, err8;
    logic [3:0]  id_out8;
    logic [63:0] res_out8;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serdiv_wb_pad_sc #(.WIDTH(64), .PAD_CYCLES(70), .TRANS_ID_BITS(4)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .issue_i(issue),
        .issue_label_i(issue_label), .in_vld_i(in_vld), .in_rdy_o(in_rdy),
        .id_i(id_in), .res_i(res_in), .res_label_i(res_label),
        .out_vld_o(out_vld), .out_rdy_i(out_rdy), .id_o(id_out),
        .res_o(res_out), .res_label_o(lab), .err_o(err)
    );

    serdiv_wb_pad_sc #(.WIDTH(64), .PAD_CYCLES(8), .TRANS_ID_BITS(4)) u_dut8 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .issue_i(issue),
        .issue_label_i(issue_label), .in_vld_i(in_vld), .in_rdy_o(in_rdy8),
        .id_i(id_in), .res_i(res_in), .res_label_i(res_label),
        .out_vld_o(out_vld8), .out_rdy_i(out_rdy), .id_o(id_out8),
        .res_o(res_out8), .res_label_o(lab8), .err_o(err8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s c%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One op issued at c0, result offered at c=cap, out_rdy high from c=rdy_at
    task automatic run_op(input string tag, input logic lbl, input int cap, input logic rl,
                          input logic [3:0] id, input logic [63:0] res, input int rdy_at,
                          input int v_first, input int v_last, input int n);
        issue = 1'b1; issue_label = lbl; in_vld = 1'b0;
        out_rdy = (rdy_at <= 0);
        tick();
        for (int c = 1; c <= n; c++) begin
            chk({tag, "_vld"}, c, 64'(out_vld), 64'(c >= v_first && c <= v_last));
            chk({tag, "_rdy"}, c, 64'(in_rdy), 64'(c <= cap));
            if (c >= v_first && c <= v_last) begin
                chk({tag, "_id"}, c, 64'(id_out), 64'(id));
                chk({tag, "_res"}, c, res_out, res);
                chk({tag, "_lab"}, c, 64'(lab), 64'(lbl | rl));
            end
            issue = 1'b0;
            in_vld = (c == cap); id_in = id; res_in = res; res_label = rl;
            out_rdy = (c >= rdy_at);
            tick();
        end
        in_vld = 1'b0; out_rdy = 1'b0; res_label = 1'b0;
        chk({tag, "_err"}, n, 64'(err), 64'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_vld", 0, 64'(out_vld), 64'd0);
        chk("rst_rdy", 0, 64'(in_rdy), 64'd0);
        chk("rst_id", 0, 64'(id_out), 64'd0);
        chk("rst_res", 0, res_out, 64'd0);
        chk("rst_lab", 0, 64'(lab), 64'd0);
        chk("rst_err", 0, 64'(err), 64'd0);
        rst_n = 1'b1;
        tick();

        run_op("t1_pub", 1'b0, 10, 1'b0, 4'd3, 64'h2A, 0, 11, 11, 13);
        run_op("t2_sec5", 1'b1, 5, 1'b0, 4'd4, 64'hDEAD_BEEF, 0, 70, 70, 71);
        run_op("t2_sec40", 1'b1, 40, 1'b0, 4'd6, 64'h1234_5678_9ABC_DEF0, 0, 70, 70, 71);
        run_op("t2_reslab", 1'b0, 20, 1'b1, 4'd2, 64'h77, 0, 70, 70, 71);
        run_op("t3_bp", 1'b1, 5, 1'b0, 4'hA, 64'hCAFE, 75, 70, 75, 77);

        // Flush in WAIT, late result ignored, new op afterwards
        issue = 1'b1; issue_label = 1'b0;
        tick();
        issue = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        chk("t4_rdy20", 20, 64'(in_rdy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_rdy21", 21, 64'(in_rdy), 64'd0);
        in_vld = 1'b1; id_in = 4'd5; res_in = 64'h55;
        tick();
        in_vld = 1'b0;
        chk("t4_vld22", 22, 64'(out_vld), 64'd0);
        chk("t4_rdy22", 22, 64'(in_rdy), 64'd0);
        run_op("t4_new", 1'b0, 4, 1'b0, 4'd7, 64'h77, 0, 5, 5, 7);

        // Pad overrun on PAD_CYCLES=8 instance
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t5_err0", 0, 64'(err8), 64'd0);
        issue = 1'b1; issue_label = 1'b1; out_rdy = 1'b1;
        id_in = 4'd1; res_in = 64'h8;
        tick();
        issue = 1'b0; issue_label = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk("t5_vld", c, 64'(out_vld8), 64'(c == 13));
            chk("t5_err", c, 64'(err8), 64'(c >= 13));
            if (c == 13) chk("t5_res", c, res_out8, 64'h8);
            in_vld = (c == 12);
            tick();
        end
        out_rdy = 1'b0;
        for (int c = 17; c < 20; c++) tick();
        chk("t5_sticky", 20, 64'(err8), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t5_rst", 0, 64'(err8), 64'd0);
        tick();

        // Issue during VALID: error flagged, pending result unchanged
        issue = 1'b1; issue_label = 1'b0; id_in = 4'd9; res_in = 64'h99;
        tick();
        for (int c = 1; c <= 9; c++) begin
            chk("t6_vld", c, 64'(out_vld), 64'(c >= 4 && c <= 8));
            chk("t6_err", c, 64'(err), 64'(c >= 7));
            if (c >= 4 && c <= 8) begin
                chk("t6_id", c, 64'(id_out), 64'd9);
                chk("t6_res", c, res_out, 64'h99);
            end
            issue = (c == 6);
            if (c == 6) begin
                id_in = 4'd2; res_in = 64'h22;
            end
            in_vld = (c == 3);
            out_rdy = (c == 8);
            tick();
        end
        in_vld = 1'b0; out_rdy = 1'b0; issue = 1'b0;

        // Asynchronous reset in the middle of WAIT
        issue = 1'b1;
        tick();
        issue = 1'b0;
        tick();
        chk("t6_wait", 2, 64'(in_rdy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_arst_rdy", 2, 64'(in_rdy), 64'd0);
        chk("t6_arst_vld", 2, 64'(out_vld), 64'd0);
        chk("t6_arst_err", 2, 64'(err), 64'd0);
        chk("t6_arst_id", 2, 64'(id_out), 64'd0);
        chk("t6_arst_res", 2, res_out, 64'd0);
        #1 rst_n = 1'b1;
        tick();
        chk("t6_idle", 3, 64'(in_rdy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
